// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bus between decode, writeback and the register-read scoreboard.
interface reg_scoreboard_if #(
    parameter int unsigned NREG = 32
);
    // decode -> scoreboard
    logic            issue_valid;
    logic            issue_we;
    logic [4:0]      issue_rd;
    logic [4:0]      issue_rs;
    logic [4:0]      issue_rt;
    logic            issue_rs_use;
    logic            issue_rt_use;
    // writeback -> scoreboard
    logic            wb_valid;
    logic [4:0]      wb_rd;
    // scoreboard -> pipeline
    logic            stall;
    logic [NREG-1:0] pend_mask;
    logic [6:0]      inflight;
    logic            idle;
    logic            err;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_rs, issue_rt,
               issue_rs_use, issue_rt_use, wb_valid, wb_rd,
        input  stall, pend_mask, inflight, idle, err
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_rs, issue_rt,
               issue_rs_use, issue_rt_use, wb_valid, wb_rd,
        output stall, pend_mask, inflight, idle, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-read hazard tracker: per-register pending-write counters between
// issue and writeback, stalling issue on RAW hazards or counter saturation.
module reg_scoreboard #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_scoreboard_if.slave sb
);
    localparam int unsigned IDX_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [6:0]       inflight_q, inflight_d;
    logic             err_q, err_d;

    logic raw_s, raw_t, sat, stall, accept;
    logic track_inc, wb_hit, retire;

    // Hazard detection from registered counters only; same-cycle writeback does not clear it.
    always_comb begin
        raw_s  = sb.issue_rs_use && (sb.issue_rs != '0) && (cnt_q[sb.issue_rs] != '0);
        raw_t  = sb.issue_rt_use && (sb.issue_rt != '0) && (cnt_q[sb.issue_rt] != '0);
        sat    = sb.issue_we && (sb.issue_rd != '0) && (cnt_q[sb.issue_rd] == CNT_MAX);
        stall  = sb.issue_valid && (raw_s || raw_t || sat);
        accept = sb.issue_valid && !stall;
    end

    // Next-state for counters, inflight total and sticky error.
    always_comb begin
        track_inc = accept && sb.issue_we && (sb.issue_rd != '0);
        wb_hit    = sb.wb_valid && (sb.wb_rd != '0);
        retire    = wb_hit && (cnt_q[sb.wb_rd] != '0);

        // Issue and retire on the same register cancel; the r0 slot stays zero.
        cnt_d[0] = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((track_inc && (sb.issue_rd == IDX_W'(i))) && !(retire && (sb.wb_rd == IDX_W'(i))))
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (!(track_inc && (sb.issue_rd == IDX_W'(i))) && (retire && (sb.wb_rd == IDX_W'(i))))
                cnt_d[i] = cnt_q[i] - 1'b1;
        end

        inflight_d = inflight_q;
        case ({track_inc, retire})
            2'b10:   inflight_d = inflight_q + 7'd1;
            2'b01:   inflight_d = inflight_q - 7'd1;
            default: inflight_d = inflight_q;
        endcase

        err_d = err_q
              | (wb_hit && (cnt_q[sb.wb_rd] == '0))
              | (retire && !track_inc && (inflight_q == '0))
              | (track_inc && !retire && (inflight_q == '1));
    end

    // State registers; reset discards all pending writes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '{default: '0};
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Output drive.
    always_comb begin
        sb.stall    = stall;
        sb.inflight = inflight_q;
        sb.idle     = (inflight_q == '0);
        sb.err      = err_q;
        for (int unsigned i = 0; i < NREG; i++)
            sb.pend_mask[i] = (cnt_q[i] != '0);
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, async reset
// sequence, and randomized traffic against an integer-count reference model.
module tb_reg_scoreboard;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    reg_scoreboard_if #(.NREG(32)) bus ();

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv, we;
        logic [4:0] rd, rs, rt;
        logic       su, tu;
        logic       wv;
        logic [4:0] wr;
        logic       exp_stall;
        logic [31:0] exp_pend;
        logic [6:0] exp_infl;
        logic       exp_err;
    } vec_t;

    vec_t vecs[15];

    // reference model state
    int mcnt[32];
    bit merr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, we, input logic [4:0] rd, rs, rt,
                         input logic su, tu, wv, input logic [4:0] wr);
        bus.issue_valid  = iv;
        bus.issue_we     = we;
        bus.issue_rd     = rd;
        bus.issue_rs     = rs;
        bus.issue_rt     = rt;
        bus.issue_rs_use = su;
        bus.issue_rt_use = tu;
        bus.wb_valid     = wv;
        bus.wb_rd        = wr;
    endtask

    function automatic vec_t mkv(logic iv, we, logic [4:0] rd, rs, rt, logic su, tu, wv,
                                 logic [4:0] wr, logic st, logic [31:0] pend, logic [6:0] infl, logic e);
        vec_t v;
        v.iv = iv; v.we = we; v.rd = rd; v.rs = rs; v.rt = rt; v.su = su; v.tu = tu;
        v.wv = wv; v.wr = wr; v.exp_stall = st; v.exp_pend = pend; v.exp_infl = infl; v.exp_err = e;
        return v;
    endfunction

    // Model: spec rules applied to plain integer counts; returns expected stall.
    function automatic bit model_step(logic iv, we, logic [4:0] rd, rs, rt, logic su, tu,
                                      logic wv, logic [4:0] wr);
        bit st;
        int pre_wb;
        st = iv && ((su && rs != 0 && mcnt[rs] > 0) ||
                    (tu && rt != 0 && mcnt[rt] > 0) ||
                    (we && rd != 0 && mcnt[rd] >= 3));
        pre_wb = mcnt[wr];
        if (iv && !st && we && rd != 0) mcnt[rd]++;
        if (wv && wr != 0) begin
            if (pre_wb > 0) mcnt[wr]--;
            else merr = 1;
        end
        return st;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) m[i] = (mcnt[i] > 0);
        return m;
    endfunction

    function automatic int model_sum();
        int s;
        s = 0;
        for (int i = 1; i < 32; i++) s += mcnt[i];
        return s;
    endfunction

    initial begin
        logic       iv, we, su, tu, wv;
        logic [4:0] rd, rs, rt, wr;
        bit         last_stall, exp_st;
        int         pending[$];

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = mkv(1,1,5,1,2,1,1, 0,0,  0, 32'h20, 1, 0);
        vecs[1]  = mkv(1,0,0,5,0,1,0, 0,0,  1, 32'h20, 1, 0);
        vecs[2]  = mkv(1,0,0,5,0,1,0, 1,5,  1, 32'h0,  0, 0);
        vecs[3]  = mkv(1,0,0,5,0,1,0, 0,0,  0, 32'h0,  0, 0);
        vecs[4]  = mkv(1,1,7,0,0,0,0, 0,0,  0, 32'h80, 1, 0);
        vecs[5]  = mkv(1,1,7,0,0,0,0, 0,0,  0, 32'h80, 2, 0);
        vecs[6]  = mkv(1,1,7,0,0,0,0, 0,0,  0, 32'h80, 3, 0);
        vecs[7]  = mkv(1,1,7,0,0,0,0, 0,0,  1, 32'h80, 3, 0);
        vecs[8]  = mkv(1,1,7,0,0,0,0, 1,7,  1, 32'h80, 2, 0);
        vecs[9]  = mkv(1,1,7,0,0,0,0, 0,0,  0, 32'h80, 3, 0);
        vecs[10] = mkv(1,1,9,0,0,0,0, 0,0,  0, 32'h280, 4, 0);
        vecs[11] = mkv(1,1,9,0,0,0,0, 1,9,  0, 32'h280, 4, 0);
        vecs[12] = mkv(1,1,0,0,0,1,1, 0,0,  0, 32'h280, 4, 0);
        vecs[13] = mkv(0,0,0,0,0,0,0, 1,12, 0, 32'h280, 4, 1);
        vecs[14] = mkv(0,0,0,0,0,0,0, 0,0,  0, 32'h280, 4, 1);

        // reset state while rst_n is held low
        #2;
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_pend", bus.pend_mask, 0);
        chk("rst_infl", 32'(bus.inflight), 0);
        chk("rst_idle", 32'(bus.idle), 1);
        chk("rst_err", 32'(bus.err), 0);
        #10 rst_n = 1'b1;
        tick();

        // directed vector table
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].iv, vecs[i].we, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                  vecs[i].su, vecs[i].tu, vecs[i].wv, vecs[i].wr);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
            tick();
            chk($sformatf("v%0d_pend", i), bus.pend_mask, vecs[i].exp_pend);
            chk($sformatf("v%0d_infl", i), 32'(bus.inflight), 32'(vecs[i].exp_infl));
            chk($sformatf("v%0d_idle", i), 32'(bus.idle), 32'(vecs[i].exp_infl == 0));
            chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].exp_err));
        end

        // asynchronous reset between clock edges clears everything immediately
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_err", 32'(bus.err), 0);
        chk("arst_infl", 32'(bus.inflight), 0);
        chk("arst_pend", bus.pend_mask, 0);
        chk("arst_idle", 32'(bus.idle), 1);
        chk("arst_stall", 32'(bus.stall), 0);
        #2 rst_n = 1'b1;
        tick();

        // stale writeback from before reset is flagged as untracked
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        chk("stale_wb_err", 32'(bus.err), 1);
        chk("stale_wb_infl", 32'(bus.inflight), 0);

        // clean reset before random traffic
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        merr = 0;
        tick();

        // randomized traffic vs reference model
        last_stall = 0;
        iv = 0; we = 0; rd = 0; rs = 0; rt = 0; su = 0; tu = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!last_stall) begin
                iv = ($urandom_range(0, 9) < 7);
                we = ($urandom_range(0, 9) < 6);
                rd = 5'($urandom_range(0, 7));
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                su = 1'($urandom_range(0, 1));
                tu = 1'($urandom_range(0, 1));
            end
            pending.delete();
            for (int r = 1; r < 32; r++) if (mcnt[r] > 0) pending.push_back(r);
            wv = 0;
            wr = 0;
            if (pending.size() > 0 && $urandom_range(0, 1) == 1) begin
                wv = 1;
                wr = 5'(pending[$urandom_range(0, pending.size() - 1)]);
            end else if ($urandom_range(0, 63) == 0) begin
                wv = 1;
                wr = 5'($urandom_range(0, 31));
            end
            drive(iv, we, rd, rs, rt, su, tu, wv, wr);
            #1;
            exp_st = model_step(iv, we, rd, rs, rt, su, tu, wv, wr);
            chk("rnd_stall", 32'(bus.stall), 32'(exp_st));
            last_stall = exp_st;
            tick();
            chk("rnd_infl", 32'(bus.inflight), 32'(model_sum()));
            chk("rnd_pend", bus.pend_mask, model_mask());
            chk("rnd_idle", 32'(bus.idle), 32'(model_sum() == 0));
            chk("rnd_err", 32'(bus.err), 32'(merr));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
